// File: rtl/tune_sequencer_if.sv
// Bundle between the note-entry logic and the tone sequencer.
// master: drives start/stop/loop_en/notes/clockSpeed/note_len,
//         observes pwm/busy/done/note_idx.
// slave:  the sequencer side of the same signals.
interface tune_sequencer_if #(
    parameter int NUM_NOTES = 6,
    parameter int NOTE_W    = 8,
    parameter int DIV_W     = 36,
    parameter int DUR_W     = 24
) ();
    localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

    logic                        start;
    logic                        stop;
    logic                        loop_en;
    logic [NUM_NOTES*NOTE_W-1:0] notes;
    logic [DIV_W-1:0]            clockSpeed;
    logic [DUR_W-1:0]            note_len;
    logic                        pwm;
    logic                        busy;
    logic                        done;
    logic [IDX_W-1:0]            note_idx;

    modport master (
        output start, stop, loop_en, notes, clockSpeed, note_len,
        input  pwm, busy, done, note_idx
    );

    modport slave (
        input  start, stop, loop_en, notes, clockSpeed, note_len,
        output pwm, busy, done, note_idx
    );
endinterface

// File: rtl/tune_sequencer.sv
// Tone sequencer: plays NUM_NOTES square-wave notes on one pwm pin.
// Ports: clk, reset (sync, active-high), bus (slave side of
// tune_sequencer_if: start/stop/loop_en/notes/clockSpeed/note_len in,
// pwm/busy/done/note_idx out, all outputs registered).
module tune_sequencer #(
    parameter int NUM_NOTES = 6,
    parameter int NOTE_W    = 8,
    parameter int DIV_W     = 36,
    parameter int DUR_W     = 24
) (
    input  logic             clk,
    input  logic             reset,
    tune_sequencer_if.slave  bus
);
    localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
    localparam int H_W   = NOTE_W + DIV_W;
    localparam int NV_W  = NUM_NOTES * NOTE_W;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t            state, state_nx;
    logic [NV_W-1:0]   notes_q, notes_nx;
    logic [DIV_W-1:0]  speed_q, speed_nx;
    logic [DUR_W-1:0]  len_q, len_nx;
    logic [IDX_W-1:0]  idx_q, idx_nx;
    logic [H_W-1:0]    tone_q, tone_nx;
    logic [DUR_W-1:0]  dur_q, dur_nx;
    logic              pwm_q, pwm_nx;
    logic              busy_q, busy_nx;
    logic              done_q, done_nx;

    logic [NOTE_W-1:0] cur_note;
    logic [H_W-1:0]    half;
    logic [DUR_W-1:0]  len_m1;
    logic              last_slot;
    logic [IDX_W-1:0]  nxt_idx;
    logic              nxt_loud;
    logic              start_loud;

    function automatic logic [NOTE_W-1:0] note_at(
        input logic [NV_W-1:0]  v,
        input logic [IDX_W-1:0] i
    );
        logic [NOTE_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_NOTES; k++) begin
            if (i == IDX_W'(k)) r = v[k*NOTE_W +: NOTE_W];
        end
        return r;
    endfunction

    // Full-width half-period; a zero factor makes the note a rest.
    assign cur_note   = note_at(notes_q, idx_q);
    assign half       = H_W'(cur_note) * H_W'(speed_q);
    assign len_m1     = (len_q == '0) ? '0 : len_q - DUR_W'(1);
    assign last_slot  = (idx_q == IDX_W'(NUM_NOTES - 1));
    assign nxt_idx    = last_slot ? '0 : idx_q + IDX_W'(1);
    assign nxt_loud   = (note_at(notes_q, nxt_idx) != '0) &&
                        (speed_q != '0);
    // First note of a new pass is judged from the live inputs
    // being snapshotted on this same edge.
    assign start_loud = (note_at(bus.notes, '0) != '0) &&
                        (bus.clockSpeed != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            notes_q <= '0;
            speed_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            tone_q  <= '0;
            dur_q   <= '0;
            pwm_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            notes_q <= notes_nx;
            speed_q <= speed_nx;
            len_q   <= len_nx;
            idx_q   <= idx_nx;
            tone_q  <= tone_nx;
            dur_q   <= dur_nx;
            pwm_q   <= pwm_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        notes_nx = notes_q;
        speed_nx = speed_q;
        len_nx   = len_q;
        idx_nx   = idx_q;
        tone_nx  = tone_q;
        dur_nx   = dur_q;
        pwm_nx   = pwm_q;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                pwm_nx  = 1'b0;
                busy_nx = 1'b0;
                idx_nx  = '0;
                tone_nx = '0;
                dur_nx  = '0;
                if (bus.start && !bus.stop) begin
                    state_nx = PLAY;
                    notes_nx = bus.notes;
                    speed_nx = bus.clockSpeed;
                    len_nx   = bus.note_len;
                    busy_nx  = 1'b1;
                    pwm_nx   = start_loud;
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    state_nx = IDLE;
                    pwm_nx   = 1'b0;
                    busy_nx  = 1'b0;
                    idx_nx   = '0;
                    tone_nx  = '0;
                    dur_nx   = '0;
                end else if (dur_q == len_m1) begin
                    // Note boundary: tone phase never carries over.
                    tone_nx = '0;
                    dur_nx  = '0;
                    if (last_slot && !bus.loop_en) begin
                        state_nx = IDLE;
                        pwm_nx   = 1'b0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = nxt_idx;
                        pwm_nx = nxt_loud;
                    end
                end else begin
                    dur_nx = dur_q + DUR_W'(1);
                    if (half == '0) begin
                        pwm_nx = 1'b0;
                    end else if (tone_q == half - H_W'(1)) begin
                        pwm_nx  = ~pwm_q;
                        tone_nx = '0;
                    end else begin
                        tone_nx = tone_q + H_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.pwm      = pwm_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.note_idx = idx_q;
endmodule

// File: tb/tb_tune_sequencer.sv
// Self-checking bench for tune_sequencer.
// Compares every cycle against a pass-position reference model.
module tb_tune_sequencer;
    localparam int N  = 6;
    localparam int NW = 8;
    localparam int DW = 36;
    localparam int LW = 24;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tune_sequencer_if #(.NUM_NOTES(N), .NOTE_W(NW), .DIV_W(DW), .DUR_W(LW)) bus ();

    tune_sequencer #(.NUM_NOTES(N), .NOTE_W(NW), .DIV_W(DW), .DUR_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc;

    // Reference model: position within the pass (m_e) plus snapshot.
    bit          m_play;
    bit          m_done;
    int          m_e;
    int          m_L;
    logic [47:0] m_notes;
    longint      m_speed;

    function automatic void model_step();
        if (reset) begin
            m_play = 0;
            m_done = 0;
        end else if (m_play) begin
            m_done = 0;
            if (bus.stop) begin
                m_play = 0;
            end else if (m_e == N * m_L - 1) begin
                if (bus.loop_en) m_e = 0;
                else begin
                    m_play = 0;
                    m_done = 1;
                end
            end else begin
                m_e++;
            end
        end else begin
            m_done = 0;
            if (bus.start && !bus.stop) begin
                m_play  = 1;
                m_e     = 0;
                m_notes = bus.notes;
                m_speed = longint'(bus.clockSpeed);
                m_L     = (bus.note_len == 0) ? 1 : int'(bus.note_len);
            end
        end
    endfunction

    function automatic logic e_pwm();
        int          k;
        longint      h;
        logic [7:0]  code;
        if (!m_play) return 1'b0;
        k    = m_e % m_L;
        code = m_notes[(m_e / m_L) * NW +: NW];
        h    = longint'(code) * m_speed;
        if (h == 0) return 1'b0;
        return ((longint'(k) / h) % 2) == 0;
    endfunction

    function automatic logic [2:0] e_idx();
        if (!m_play) return 3'd0;
        return 3'(m_e / m_L);
    endfunction

    function automatic logic [47:0] rand_notes(input int hi);
        logic [47:0] v;
        for (int k = 0; k < N; k++) v[k*NW +: NW] = 8'($urandom_range(0, hi));
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_defaults();
        bus.notes      = {8'd5, 8'd5, 8'd15, 8'd8, 8'd10, 8'd5};
        bus.clockSpeed = 36'd2;
        bus.note_len   = 24'd40;
        bus.loop_en    = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
    endtask

    task automatic test_reset();
        set_defaults();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.pwm, bus.busy, bus.done, bus.note_idx} !== 6'd0) begin
            errors++;
            $display("FAIL reset got %b%b%b idx=%0d exp all zero",
                     bus.pwm, bus.busy, bus.done, bus.note_idx);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int done_at = -1;
        int dn = 0;
        set_defaults();
        cyc = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 250; i++) begin
            tick();
            bus.start = 1'b0;
            checks++;
            if (bus.pwm !== e_pwm() || bus.busy !== m_play ||
                bus.done !== m_done || bus.note_idx !== e_idx()) begin
                errors++;
                $display("FAIL basic cyc=%0d got %b%b%b/%0d exp %b%b%b/%0d",
                         cyc, bus.pwm, bus.busy, bus.done, bus.note_idx,
                         e_pwm(), m_play, m_done, e_idx());
            end
            if (bus.done === 1'b1) begin dn++; done_at = cyc; end
        end
        checks++;
        if (done_at != 241 || dn != 1) begin
            errors++;
            $display("FAIL basic_done got cyc=%0d count=%0d exp cyc=241 count=1",
                     done_at, dn);
        end
    endtask

    task automatic test_rest_zero_len();
        int done_at = -1;
        set_defaults();
        bus.notes[2*NW +: NW] = 8'd0;
        bus.note_len = 24'd0;
        cyc = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            bus.start = 1'b0;
            checks++;
            if (bus.pwm !== e_pwm() || bus.busy !== m_play ||
                bus.done !== m_done || bus.note_idx !== e_idx()) begin
                errors++;
                $display("FAIL rest cyc=%0d got %b%b%b/%0d exp %b%b%b/%0d",
                         cyc, bus.pwm, bus.busy, bus.done, bus.note_idx,
                         e_pwm(), m_play, m_done, e_idx());
            end
            if (bus.done === 1'b1) done_at = cyc;
        end
        checks++;
        if (done_at != 7) begin
            errors++;
            $display("FAIL rest_done got cyc=%0d exp cyc=7", done_at);
        end
    endtask

    task automatic test_loop();
        int done_at = -1;
        int dn = 0;
        set_defaults();
        bus.loop_en = 1'b1;
        cyc = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick();
            bus.start = 1'b0;
            if (cyc == 300) bus.loop_en = 1'b0;
            checks++;
            if (bus.pwm !== e_pwm() || bus.busy !== m_play ||
                bus.done !== m_done || bus.note_idx !== e_idx()) begin
                errors++;
                $display("FAIL loop cyc=%0d got %b%b%b/%0d exp %b%b%b/%0d",
                         cyc, bus.pwm, bus.busy, bus.done, bus.note_idx,
                         e_pwm(), m_play, m_done, e_idx());
            end
            if (cyc == 241) begin
                checks++;
                if (bus.note_idx !== 3'd0 || bus.pwm !== 1'b1 || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL loop_wrap got idx=%0d pwm=%b busy=%b exp 0 1 1",
                             bus.note_idx, bus.pwm, bus.busy);
                end
            end
            if (bus.done === 1'b1) begin dn++; done_at = cyc; end
        end
        checks++;
        if (done_at != 481 || dn != 1) begin
            errors++;
            $display("FAIL loop_done got cyc=%0d count=%0d exp cyc=481 count=1",
                     done_at, dn);
        end
    endtask

    task automatic test_stop();
        int dn = 0;
        set_defaults();
        cyc = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            bus.start = 1'b0;
            bus.stop = (cyc == 55);
            checks++;
            if (bus.pwm !== e_pwm() || bus.busy !== m_play ||
                bus.done !== m_done || bus.note_idx !== e_idx()) begin
                errors++;
                $display("FAIL stop cyc=%0d got %b%b%b/%0d exp %b%b%b/%0d",
                         cyc, bus.pwm, bus.busy, bus.done, bus.note_idx,
                         e_pwm(), m_play, m_done, e_idx());
            end
            if (cyc == 56) begin
                checks++;
                if ({bus.pwm, bus.busy, bus.note_idx} !== 5'd0) begin
                    errors++;
                    $display("FAIL stop_idle got pwm=%b busy=%b idx=%0d exp 0 0 0",
                             bus.pwm, bus.busy, bus.note_idx);
                end
            end
            if (bus.done === 1'b1) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL stop_done got %0d pulses exp 0", dn);
        end
    endtask

    task automatic test_reset_mid();
        set_defaults();
        cyc = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            bus.start = 1'b0;
            reset = (cyc == 100);
            if (cyc == 101) begin
                checks++;
                if ({bus.pwm, bus.busy, bus.done, bus.note_idx} !== 6'd0) begin
                    errors++;
                    $display("FAIL reset_mid got %b%b%b/%0d exp all zero",
                             bus.pwm, bus.busy, bus.done, bus.note_idx);
                end
                bus.notes      = rand_notes(9);
                bus.clockSpeed = 36'($urandom_range(1, 3));
                bus.start      = 1'b1;
            end
            checks++;
            if (bus.pwm !== e_pwm() || bus.busy !== m_play ||
                bus.done !== m_done || bus.note_idx !== e_idx()) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got %b%b%b/%0d exp %b%b%b/%0d",
                         cyc, bus.pwm, bus.busy, bus.done, bus.note_idx,
                         e_pwm(), m_play, m_done, e_idx());
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_isolation();
        int done_at = -1;
        set_defaults();
        cyc = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 250; i++) begin
            tick();
            bus.start      = 1'b0;
            bus.notes      = rand_notes(255);
            bus.clockSpeed = 36'($urandom_range(0, 7));
            bus.note_len   = 24'($urandom_range(0, 50));
            checks++;
            if (bus.pwm !== e_pwm() || bus.busy !== m_play ||
                bus.done !== m_done || bus.note_idx !== e_idx()) begin
                errors++;
                $display("FAIL isolation cyc=%0d got %b%b%b/%0d exp %b%b%b/%0d",
                         cyc, bus.pwm, bus.busy, bus.done, bus.note_idx,
                         e_pwm(), m_play, m_done, e_idx());
            end
            if (bus.done === 1'b1) done_at = cyc;
        end
        checks++;
        if (done_at != 241) begin
            errors++;
            $display("FAIL isolation_done got cyc=%0d exp cyc=241", done_at);
        end
    endtask

    task automatic test_random();
        set_defaults();
        cyc = 0;
        for (int i = 0; i < 4000; i++) begin
            bus.start      = ($urandom_range(0, 7) == 0);
            bus.stop       = ($urandom_range(0, 63) == 0);
            bus.loop_en    = ($urandom_range(0, 3) == 0);
            reset          = ($urandom_range(0, 499) == 0);
            bus.notes      = rand_notes(4);
            bus.clockSpeed = 36'($urandom_range(0, 3));
            bus.note_len   = 24'($urandom_range(0, 12));
            tick();
            checks++;
            if (bus.pwm !== e_pwm() || bus.busy !== m_play ||
                bus.done !== m_done || bus.note_idx !== e_idx()) begin
                errors++;
                $display("FAIL random cyc=%0d got %b%b%b/%0d exp %b%b%b/%0d",
                         cyc, bus.pwm, bus.busy, bus.done, bus.note_idx,
                         e_pwm(), m_play, m_done, e_idx());
            end
        end
        reset = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    initial begin
        m_play  = 0;
        m_done  = 0;
        m_e     = 0;
        m_L     = 1;
        m_notes = '0;
        m_speed = 0;
        cyc     = 0;
        reset   = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_rest_zero_len();
        test_loop();
        test_stop();
        test_reset_mid();
        test_isolation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
